fpu_share_arbiter: RTL and testbench

Shares one `fpnew_top` instance between `NumReq` requesters, such as the scalar FP pipe and vector lanes, under valid/ready handshakes. Issue is round-robin and fair. The block prepends a requester ID to the FPU tag and routes each result back to the requester that issued it. It keeps a per-requester outstanding-op count with a cap and a global flush. It sits between the issue stages and the FPU, and is purely a control block: payload passes through unmodified.

---
 rtl/fpu_share_pkg.sv | 68 ++++++
 rtl/rr_grant_lock.sv | 76 +++++++
 rtl/fpu_share_arbiter.sv | 140 ++++++++++++++
 tb/tb_fpu_share_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_share_pkg.sv
// ============================================================================
// fpu_share_pkg : shared request/response types for the FPU share arbiter
// Revision      : 1.0
// ============================================================================
`default_nettype none

package fpu_share_pkg;

    localparam int unsigned FpWidth     = 64;
    localparam int unsigned FpTagWidth  = 4;
    localparam int unsigned NumOperands = 3;

    // Encodings mirror fpnew_pkg so the payload drops straight onto fpnew_top.
    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [1:0] {
        INT8  = 2'd0,
        INT16 = 2'd1,
        INT32 = 2'd2,
        INT64 = 2'd3
    } int_format_e;

    typedef struct packed {
        logic [NumOperands-1:0][FpWidth-1:0] operands;
        roundmode_e                          rnd_mode;
        operation_e                          op;
        logic                                op_mod;
        fp_format_e                          src_fmt;
        fp_format_e                          dst_fmt;
        int_format_e                         int_fmt;
        logic                                vectorial_op;
        logic [FpTagWidth-1:0]               tag;
    } fpu_req_t;

    typedef struct packed {
        logic [FpWidth-1:0]    result;
        logic [4:0]            status;
        logic [FpTagWidth-1:0] tag;
    } fpu_rsp_t;

    function automatic int unsigned calc_id_width(input int unsigned num_req);
        return (num_req <= 1) ? 1 : $clog2(num_req);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_grant_lock.sv
// ============================================================================
// rr_grant_lock : round-robin pick with a grant lock held until the handshake
// Revision      : 1.0
// ============================================================================
`default_nettype none

module rr_grant_lock #(
    parameter int unsigned NumReq  = 2,
    parameter int unsigned IdWidth = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic [NumReq-1:0]  eligible_i,
    input  logic               advance_i,
    output logic               grant_valid_o,
    output logic [IdWidth-1:0] grant_idx_o,
    output logic               lock_valid_o
);

    logic [IdWidth-1:0] rr_ptr;
    logic [IdWidth-1:0] lock_idx;
    logic               lock_valid;
    logic               pick_valid;
    logic [IdWidth-1:0] pick_idx;
    logic [IdWidth-1:0] scan_idx;
    logic [IdWidth-1:0] next_ptr;

    // First eligible index at or after rr_ptr, wrapping at NumReq.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_ptr;
        scan_idx   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            scan_idx = IdWidth'((32'(rr_ptr) + k) % NumReq);
            if (!pick_valid && eligible_i[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        grant_valid_o = pick_valid;
        grant_idx_o   = pick_idx;
        if (lock_valid) begin
            grant_valid_o = eligible_i[lock_idx];
            grant_idx_o   = lock_idx;
        end
    end

    assign next_ptr     = (grant_idx_o == IdWidth'(NumReq - 1)) ? '0 : grant_idx_o + 1'b1;
    assign lock_valid_o = lock_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_idx   <= '0;
        end else if (clear_i) begin
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_idx   <= '0;
        end else begin
            if (advance_i) begin
                rr_ptr <= next_ptr;
            end
            // A presented-but-unaccepted grant is pinned so the FPU sees a stable request.
            lock_valid <= grant_valid_o && !advance_i;
            lock_idx   <= grant_idx_o;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_share_arbiter.sv
// ============================================================================
// fpu_share_arbiter : shares one FPU among NumReq requesters, routes results
// Revision          : 1.0
// ============================================================================
`default_nettype none

module fpu_share_arbiter
    import fpu_share_pkg::*;
#(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned Width          = FpWidth,
    parameter int unsigned ReqTagWidth    = FpTagWidth,
    parameter int unsigned MaxOutstanding = 8,
    localparam int unsigned IdWidth       = calc_id_width(NumReq),
    localparam int unsigned TagWidth      = IdWidth + ReqTagWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  fpu_req_t [NumReq-1:0]   req_data_i,
    output logic [NumReq-1:0]       rsp_valid_o,
    input  logic [NumReq-1:0]       rsp_ready_i,
    output fpu_rsp_t                rsp_data_o,
    output logic                    fpu_in_valid_o,
    input  logic                    fpu_in_ready_i,
    output fpu_req_t                fpu_req_o,
    output logic [TagWidth-1:0]     fpu_tag_o,
    input  logic                    fpu_out_valid_i,
    output logic                    fpu_out_ready_o,
    input  logic [Width-1:0]        fpu_result_i,
    input  logic [4:0]              fpu_status_i,
    input  logic [TagWidth-1:0]     fpu_tag_i,
    output logic                    fpu_flush_o,
    input  logic                    fpu_busy_i,
    output logic                    busy_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

    logic [NumReq-1:0]   eligible;
    logic [NumReq-1:0]   issue_hs;
    logic [NumReq-1:0]   rsp_hs;
    logic [NumReq-1:0]   cnt_nz;
    logic [CntWidth-1:0] cnt [NumReq];

    logic                grant_valid;
    logic [IdWidth-1:0]  grant_idx;
    logic                lock_valid;
    logic                issue_open;
    logic                issue_fire;
    fpu_req_t            sel_req;

    logic [IdWidth-1:0]  rsp_id;
    logic                id_known;

    rr_grant_lock #(
        .NumReq  (NumReq),
        .IdWidth (IdWidth)
    ) u_rr_grant_lock (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (flush_i),
        .eligible_i    (eligible),
        .advance_i     (issue_fire),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx),
        .lock_valid_o  (lock_valid)
    );

    // Reset also gates the combinational outputs so they go idle without a clock.
    assign issue_open     = rst_ni && !flush_i;
    assign fpu_in_valid_o = grant_valid && issue_open;
    assign issue_fire     = fpu_in_valid_o && fpu_in_ready_i;
    assign sel_req        = req_data_i[grant_idx];
    assign fpu_req_o      = sel_req;
    assign fpu_tag_o      = {grant_idx, sel_req.tag[ReqTagWidth-1:0]};
    assign fpu_flush_o    = flush_i;

    always_comb begin
        req_ready_o = '0;
        if (grant_valid && issue_open) begin
            req_ready_o[grant_idx] = fpu_in_ready_i;
        end
    end

    assign rsp_id     = fpu_tag_i[TagWidth-1 -: IdWidth];
    assign id_known   = (32'(rsp_id) < NumReq);
    assign rsp_data_o = '{result: fpu_result_i, status: fpu_status_i, tag: fpu_tag_i[ReqTagWidth-1:0]};

    // Results carrying an unmapped ID are swallowed so the FPU never stalls on them.
    always_comb begin
        rsp_valid_o     = '0;
        fpu_out_ready_o = 1'b0;
        if (rst_ni) begin
            if (id_known) begin
                rsp_valid_o[rsp_id] = fpu_out_valid_i;
                fpu_out_ready_o     = rsp_ready_i[rsp_id];
            end else begin
                fpu_out_ready_o = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NumReq; i++) begin : g_cnt
        assign eligible[i] = req_valid_i[i] && (cnt[i] < CntMax);
        assign issue_hs[i] = issue_fire && (grant_idx == IdWidth'(i));
        assign rsp_hs[i]   = rsp_valid_o[i] && rsp_ready_i[i];
        assign cnt_nz[i]   = |cnt[i];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt[i] <= '0;
            end else if (flush_i) begin
                cnt[i] <= '0;
            end else if (issue_hs[i] && !rsp_hs[i]) begin
                cnt[i] <= cnt[i] + 1'b1;
            end else if (rsp_hs[i] && !issue_hs[i] && cnt_nz[i]) begin
                cnt[i] <= cnt[i] - 1'b1;
            end
        end

`ifndef SYNTHESIS
        assert_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (rsp_hs[i] && !issue_hs[i] && !flush_i) |-> cnt_nz[i]);
`endif
    end

    assign busy_o = (|cnt_nz) || fpu_busy_i || lock_valid;

`ifndef SYNTHESIS
    assert_unknown_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fpu_out_valid_i |-> id_known);
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpu_share_arbiter.sv
// ============================================================================
// tb_fpu_share_arbiter : directed self-checking bench for fpu_share_arbiter
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_fpu_share_arbiter;
    import fpu_share_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n, flush, in_ready, out_valid, fpu_busy;
    logic [1:0]     req_valid, rsp_ready;
    fpu_req_t [1:0] req_data;
    logic [63:0]    result;
    logic [4:0]     status, out_tag;

    logic [1:0] req_ready, rsp_valid;
    fpu_rsp_t   rsp_data;
    logic       in_valid, out_ready, fpu_flush, busy;
    fpu_req_t   fpu_req;
    logic [4:0] fpu_tag;

    logic [1:0] c_req_ready, c_rsp_valid;
    fpu_rsp_t   c_rsp_data;
    logic       c_in_valid, c_out_ready, c_fpu_flush, c_busy;
    fpu_req_t   c_fpu_req;
    logic [4:0] c_fpu_tag;

    int tests_run    = 0;
    int tests_failed = 0;

    fpu_share_arbiter #(.NumReq(2), .MaxOutstanding(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .fpu_in_valid_o(in_valid), .fpu_in_ready_i(in_ready), .fpu_req_o(fpu_req), .fpu_tag_o(fpu_tag),
        .fpu_out_valid_i(out_valid), .fpu_out_ready_o(out_ready), .fpu_result_i(result),
        .fpu_status_i(status), .fpu_tag_i(out_tag),
        .fpu_flush_o(fpu_flush), .fpu_busy_i(fpu_busy), .busy_o(busy)
    );

    fpu_share_arbiter #(.NumReq(2), .MaxOutstanding(2)) dut_cap (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(c_req_ready), .req_data_i(req_data),
        .rsp_valid_o(c_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(c_rsp_data),
        .fpu_in_valid_o(c_in_valid), .fpu_in_ready_i(in_ready), .fpu_req_o(c_fpu_req), .fpu_tag_o(c_fpu_tag),
        .fpu_out_valid_i(out_valid), .fpu_out_ready_o(c_out_ready), .fpu_result_i(result),
        .fpu_status_i(status), .fpu_tag_i(out_tag),
        .fpu_flush_o(c_fpu_flush), .fpu_busy_i(fpu_busy), .busy_o(c_busy)
    );

    function automatic fpu_req_t mk_req(input int who, input logic [3:0] tag);
        fpu_req_t r;
        r = '0;
        r.operands[0] = 64'h1000 + 64'(who);
        r.operands[1] = 64'h2000 + 64'(tag);
        r.operands[2] = 64'h3000 + 64'(who * 16);
        r.op          = (who == 0) ? ADD : MUL;
        r.src_fmt     = FP64;
        r.dst_fmt     = FP64;
        r.tag         = tag;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0; flush = 1'b0; req_valid = '0; rsp_ready = '0; in_ready = 1'b0;
        out_valid = 1'b0; fpu_busy = 1'b0; out_tag = '0; result = '0; status = '0;
        req_data[0] = mk_req(0, 4'h1);
        req_data[1] = mk_req(1, 4'h2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; rsp_ready = '0; out_valid = 1'b0; fpu_busy = 1'b0;
        out_tag = '0; result = '0; status = '0;
        req_data[0] = mk_req(0, 4'h1);
        req_data[1] = mk_req(1, 4'h2);
        req_valid = 2'b11; in_ready = 1'b1;
        #1;
        tests_run++; if (in_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_in_valid: got %b want 0", in_valid); end
        tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        tests_run++; if ({rsp_valid, out_ready, busy} !== 4'b0000) begin tests_failed++; $display("FAIL reset_rsp_busy: got %b want 0000", {rsp_valid, out_ready, busy}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++; if (fpu_tag !== 5'h01 || req_ready !== 2'b01) begin tests_failed++; $display("FAIL reset_first_grant: got tag %h ready %b want tag 01 ready 01", fpu_tag, req_ready); end
        tick();
        @(negedge clk);
        tests_run++; if (fpu_tag !== 5'h12 || req_ready !== 2'b10) begin tests_failed++; $display("FAIL reset_second_grant: got tag %h ready %b want tag 12 ready 10", fpu_tag, req_ready); end
        tick();
    endtask

    task automatic test_contention;
        logic [4:0] exp_tag;
        apply_reset();
        req_valid = 2'b11; in_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req_data[0] = mk_req(0, 4'(k));
            req_data[1] = mk_req(1, 4'(k + 8));
            exp_tag = (k % 2 == 0) ? {1'b0, 4'(k)} : {1'b1, 4'(k + 8)};
            @(negedge clk);
            tests_run++; if (fpu_tag !== exp_tag || req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                tests_failed++; $display("FAIL contention_grant[%0d]: got tag %h ready %b want tag %h", k, fpu_tag, req_ready, exp_tag); end
            tests_run++; if (fpu_req !== req_data[k % 2]) begin
                tests_failed++; $display("FAIL contention_payload[%0d]: got %h want %h", k, fpu_req, req_data[k % 2]); end
            tick();
        end
    endtask

    task automatic test_stall;
        apply_reset();
        req_valid = 2'b01; in_ready = 1'b1;
        tick();
        req_valid = 2'b01; in_ready = 1'b0;
        @(negedge clk);
        tests_run++; if (in_valid !== 1'b1 || fpu_tag !== 5'h01 || req_ready !== 2'b00) begin
            tests_failed++; $display("FAIL stall_start: got valid %b tag %h ready %b want 1 01 00", in_valid, fpu_tag, req_ready); end
        tick();
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++; if (fpu_tag !== 5'h01 || fpu_req !== req_data[0] || req_ready !== 2'b00) begin
                tests_failed++; $display("FAIL stall_hold[%0d]: got tag %h ready %b want tag 01 ready 00", k, fpu_tag, req_ready); end
            tick();
        end
        in_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (fpu_tag !== 5'h01 || req_ready !== 2'b01) begin
            tests_failed++; $display("FAIL stall_release: got tag %h ready %b want tag 01 ready 01", fpu_tag, req_ready); end
        tick();
        in_ready = 1'b0;
        @(negedge clk);
        tests_run++; if (fpu_tag !== 5'h12) begin tests_failed++; $display("FAIL stall_next: got tag %h want 12", fpu_tag); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if ({in_valid, busy, req_ready} !== 4'b0000) begin
            tests_failed++; $display("FAIL async_reset: got valid/busy/ready %b want 0000", {in_valid, busy, req_ready}); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_cap;
        apply_reset();
        req_valid = 2'b01; in_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tests_run++; if (c_req_ready !== 2'b01) begin tests_failed++; $display("FAIL cap_fill[%0d]: got ready %b want 01", k, c_req_ready); end
            tick();
        end
        @(negedge clk);
        tests_run++; if (c_in_valid !== 1'b0 || c_req_ready !== 2'b00) begin
            tests_failed++; $display("FAIL cap_full: got valid %b ready %b want 0 00", c_in_valid, c_req_ready); end
        tick();
        req_valid = 2'b11;
        @(negedge clk);
        tests_run++; if (c_fpu_tag !== 5'h12 || c_req_ready !== 2'b10) begin
            tests_failed++; $display("FAIL cap_other: got tag %h ready %b want 12 10", c_fpu_tag, c_req_ready); end
        tick();
        req_valid = 2'b01; out_valid = 1'b1; out_tag = 5'h03; rsp_ready = 2'b01;
        @(negedge clk);
        tests_run++; if (c_rsp_valid !== 2'b01 || c_out_ready !== 1'b1 || c_in_valid !== 1'b0) begin
            tests_failed++; $display("FAIL cap_boundary: got rsp %b ordy %b valid %b want 01 1 0", c_rsp_valid, c_out_ready, c_in_valid); end
        tick();
        out_valid = 1'b0; rsp_ready = 2'b00;
        @(negedge clk);
        tests_run++; if (c_in_valid !== 1'b1 || c_req_ready !== 2'b01 || c_fpu_tag !== 5'h01) begin
            tests_failed++; $display("FAIL cap_regrant: got valid %b ready %b tag %h want 1 01 01", c_in_valid, c_req_ready, c_fpu_tag); end
        tick();
    endtask

    task automatic test_routing;
        apply_reset();
        req_valid = 2'b10; in_ready = 1'b1;
        @(negedge clk);
        tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL route_issue: got ready %b want 10", req_ready); end
        tick();
        req_valid = 2'b00; in_ready = 1'b0;
        out_valid = 1'b1; out_tag = 5'h1A; result = 64'hDEAD_BEEF_0123_4567; status = 5'h11; rsp_ready = 2'b01;
        @(negedge clk);
        tests_run++; if (rsp_valid !== 2'b10 || out_ready !== 1'b0) begin
            tests_failed++; $display("FAIL route_backpressure: got rsp %b ordy %b want 10 0", rsp_valid, out_ready); end
        tests_run++; if (rsp_data !== {64'hDEAD_BEEF_0123_4567, 5'h11, 4'hA}) begin
            tests_failed++; $display("FAIL route_data: got %h want %h", rsp_data, {64'hDEAD_BEEF_0123_4567, 5'h11, 4'hA}); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL route_busy_before: got %b want 1", busy); end
        tick();
        rsp_ready = 2'b11;
        @(negedge clk);
        tests_run++; if (rsp_valid !== 2'b10 || out_ready !== 1'b1) begin
            tests_failed++; $display("FAIL route_accept: got rsp %b ordy %b want 10 1", rsp_valid, out_ready); end
        tick();
        out_valid = 1'b0; rsp_ready = 2'b00;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            tests_failed++; $display("FAIL route_decrement: got busy %b rsp %b want 0 00", busy, rsp_valid); end
        tick();
    endtask

    task automatic test_flush;
        apply_reset();
        req_valid = 2'b11; in_ready = 1'b1;
        repeat (4) tick();
        req_valid = 2'b01;
        tick();
        req_valid = 2'b10; in_ready = 1'b0;
        @(negedge clk);
        tests_run++; if (fpu_tag !== 5'h12 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL flush_setup: got tag %h busy %b want 12 1", fpu_tag, busy); end
        tick();
        flush = 1'b1; req_valid = 2'b11; in_ready = 1'b1;
        out_valid = 1'b1; out_tag = 5'h05; rsp_ready = 2'b01;
        @(negedge clk);
        tests_run++; if (fpu_flush !== 1'b1 || in_valid !== 1'b0 || req_ready !== 2'b00) begin
            tests_failed++; $display("FAIL flush_cycle: got flush %b valid %b ready %b want 1 0 00", fpu_flush, in_valid, req_ready); end
        tests_run++; if (rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL flush_route: got rsp %b want 01", rsp_valid); end
        tick();
        flush = 1'b0; req_valid = 2'b00; in_ready = 1'b0; out_valid = 1'b0; rsp_ready = 2'b00;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0 || fpu_flush !== 1'b0) begin
            tests_failed++; $display("FAIL flush_cleared: got busy %b flush %b want 0 0", busy, fpu_flush); end
        fpu_busy = 1'b1;
        #1;
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL flush_fpu_busy: got %b want 1", busy); end
        tick();
        fpu_busy = 1'b0; req_valid = 2'b11;
        @(negedge clk);
        tests_run++; if (fpu_tag !== 5'h01) begin tests_failed++; $display("FAIL flush_ptr_reset: got tag %h want 01", fpu_tag); end
        tick();
    endtask

    task automatic test_back_to_back;
        apply_reset();
        req_valid = 2'b01; in_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_data[0] = mk_req(0, 4'(k + 4));
            @(negedge clk);
            tests_run++; if (req_ready !== 2'b01 || fpu_tag !== {1'b0, 4'(k + 4)}) begin
                tests_failed++; $display("FAIL b2b[%0d]: got ready %b tag %h want 01 %h", k, req_ready, fpu_tag, {1'b0, 4'(k + 4)}); end
            tick();
        end
        req_valid = 2'b00;
        @(negedge clk);
        tests_run++; if (busy !== 1'b1 || in_valid !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_outstanding: got busy %b valid %b want 1 0", busy, in_valid); end
        tick();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_stall();
        test_cap();
        test_routing();
        test_flush();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
